// File: rtl/memory_stage_if.sv
// memory_stage_if: memory-stage bus between execute/fetch values and write-back.
//   icode      : instruction code of the current instruction
//   valA       : register A value (write data or read address)
//   valE       : ALU result (access address)
//   valP       : incremented PC (data written by call)
//   valM       : data read from memory
//   dmem_error : access address out of range
interface memory_stage_if;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        dmem_error;

    modport master (output icode, valA, valE, valP, input valM, dmem_error);
    modport slave  (input icode, valA, valE, valP, output valM, dmem_error);
endinterface

// File: rtl/memory_stage.sv
// memory_stage: SEQ Y86-64 memory stage with a word-indexed 64-bit data memory.
//   clk : rising-edge clock, writes commit here
//   rst : asynchronous active-high reset, clears every memory word
//   bus : memory_stage_if slave (icode/valA/valE/valP in, valM/dmem_error out)
module memory_stage #(
    parameter int DEPTH = 256
) (
    input logic           clk,
    input logic           rst,
    memory_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic          rd;
    logic          wr;
    logic          in_range;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [AW-1:0] idx;

    always_comb begin
        rd       = bus.icode inside {4'h5, 4'h9, 4'hB};
        wr       = bus.icode inside {4'h4, 4'h8, 4'hA};
        // ret/popq read through the stack pointer held in valA
        addr     = (bus.icode == 4'h9 || bus.icode == 4'hB) ? bus.valA : bus.valE;
        wdata    = (bus.icode == 4'h8) ? bus.valP : bus.valA;
        // full-width compare so high address bits never alias into the array
        in_range = addr < 64'(DEPTH);
        idx      = addr[AW-1:0];
        bus.dmem_error = (rd || wr) && !in_range;
        bus.valM       = (rd && in_range) ? mem_q[idx] : 64'd0;
        mem_d = mem_q;
        if (wr && in_range) mem_d[idx] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'd0;
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and randomized checks of memory_stage against a sparse-memory model.
module tb_memory_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_stage_if bus ();
    memory_stage #(.DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] mdl [longint unsigned];

    function automatic bit is_rd(input logic [3:0] ic);
        return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
    endfunction

    function automatic bit is_wr(input logic [3:0] ic);
        return ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
    endfunction

    function automatic logic [63:0] eff_addr(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e);
        return (ic == 4'h9 || ic == 4'hB) ? a : e;
    endfunction

    function automatic logic [63:0] exp_valm(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e);
        logic [63:0] ad;
        ad = eff_addr(ic, a, e);
        if (!is_rd(ic) || ad >= 256) return 64'd0;
        return mdl.exists(ad) ? mdl[ad] : 64'd0;
    endfunction

    function automatic logic [63:0] exp_err(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e);
        return {63'd0, (is_rd(ic) || is_wr(ic)) && eff_addr(ic, a, e) >= 256};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e, input logic [63:0] p);
        bus.icode = ic;
        bus.valA  = a;
        bus.valE  = e;
        bus.valP  = p;
    endtask

    // combinational probe against fixed expectations, no clock edge
    task automatic peek(input string tag, input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] p, input logic [63:0] em, input logic [63:0] ee);
        drive(ic, a, e, p);
        #1;
        check({tag, ".valM"}, bus.valM, em);
        check({tag, ".err"}, {63'd0, bus.dmem_error}, ee);
    endtask

    // one full cycle checked against the model, model commits the write after the edge
    task automatic step(input string tag, input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] p);
        logic [63:0] ad;
        drive(ic, a, e, p);
        #1;
        check({tag, ".valM"}, bus.valM, exp_valm(ic, a, e));
        check({tag, ".err"}, {63'd0, bus.dmem_error}, exp_err(ic, a, e));
        @(posedge clk);
        ad = eff_addr(ic, a, e);
        if (!rst && is_wr(ic) && ad < 256) mdl[ad] = (ic == 4'h8) ? p : a;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ic;
        logic [63:0] a, e, p;
        logic [3:0] noacc [6];
        noacc = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7};
        drive(4'h0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl.delete();

        peek("t1", 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        step("t2w", 4'h4, 64'd1000, 64'd100, 64'd0);
        peek("t2r", 4'h5, 64'd0, 64'd100, 64'd0, 64'd1000, 64'd0);
        step("t3w", 4'h8, 64'd0, 64'd200, 64'd2000);
        peek("t3ret", 4'h9, 64'd100, 64'd0, 64'd0, 64'd1000, 64'd0);
        peek("t3pop", 4'hB, 64'd200, 64'd0, 64'd0, 64'd2000, 64'd0);
        step("t4w", 4'hA, 64'd420, 64'd69, 64'd0);
        peek("t4r", 4'h5, 64'd0, 64'd69, 64'd0, 64'd420, 64'd0);
        peek("t5e", 4'h4, 64'd69, 64'd420, 64'd0, 64'd0, 64'd1);
        step("t5w", 4'h4, 64'd69, 64'd420, 64'd0);
        peek("t5r", 4'h5, 64'd0, 64'd420, 64'd0, 64'd0, 64'd1);
        peek("t5alias", 4'h5, 64'd0, 64'd164, 64'd0, 64'd0, 64'd0);
        peek("t5hi", 4'h5, 64'd0, 64'h1_0000_0064, 64'd0, 64'd0, 64'd1);
        peek("t5edge255", 4'h5, 64'd0, 64'd255, 64'd0, 64'd0, 64'd0);
        peek("t5edge256", 4'h9, 64'd256, 64'd0, 64'd0, 64'd0, 64'd1);
        foreach (noacc[i]) peek($sformatf("t6ic%0d", noacc[i]), noacc[i], 64'd420, 64'd420, 64'd0, 64'd0, 64'd0);
        step("t6nw", 4'h3, 64'd7, 64'd5, 64'd9);
        peek("t6nr", 4'h5, 64'd0, 64'd5, 64'd0, 64'd0, 64'd0);

        for (int i = 0; i < 400; i++) begin
            ic = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 31));
            e = ($urandom_range(0, 7) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) e = 64'($urandom_range(254, 257));
            p = {32'($urandom), 32'($urandom)};
            step($sformatf("rnd%0d", i), ic, a, e, p);
        end

        step("rstw", 4'h4, 64'hDEAD_BEEF, 64'd7, 64'd0);
        peek("rstpre", 4'h5, 64'd0, 64'd7, 64'd0, 64'hDEAD_BEEF, 64'd0);
        drive(4'h4, 64'd123, 64'd7, 64'd0);
        #1;
        rst = 1'b1;
        mdl.delete();
        peek("rstnow", 4'h5, 64'd0, 64'd7, 64'd0, 64'd0, 64'd0);
        peek("rstnow100", 4'h5, 64'd0, 64'd100, 64'd0, 64'd0, 64'd0);
        drive(4'h4, 64'd555, 64'd9, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        peek("rst7", 4'h5, 64'd0, 64'd7, 64'd0, 64'd0, 64'd0);
        peek("rst9", 4'h5, 64'd0, 64'd9, 64'd0, 64'd0, 64'd0);
        peek("rst200", 4'hB, 64'd200, 64'd0, 64'd0, 64'd0, 64'd0);
        step("postw", 4'h8, 64'd0, 64'd255, 64'h1234);
        step("postr", 4'h9, 64'd255, 64'd0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
